// File: rtl/latch_bank_ctrl.sv
// latch_bank_ctrl
//   Write controller for a bank of level-sensitive D latches. Two requesters
//   compete for the bank. Each write runs as SETUP, OPEN and HOLD phases:
//   lat_d settles one cycle before the selected enable rises and stays put
//   one cycle after it falls, so no latch ever sees a d/en race.
//
// Parameters
//   WIDTH        data bits per latch entry
//   DEPTH        number of latch entries (one enable each)
//   ADDR_W       address width, 2**ADDR_W >= DEPTH
//   OPEN_CYCLES  cycles the enable stays high, 1..15
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   req0/addr0/data0/ack0  requester 0 handshake (req held until ack)
//   req1/addr1/data1/ack1  requester 1 handshake
//   err                    pulses with ack when the granted address >= DEPTH
//   lat_d                  shared data bus to every latch d input
//   lat_en                 one-hot-or-zero enables to the latch en inputs
//   busy                   high whenever the FSM is outside IDLE
//
// Build option
//   LATCH_BANK_CTRL_RR_EN  defined: round-robin tie break (requester 0 wins
//                          the first tie after reset). Undefined: requester 0
//                          always wins ties.
module latch_bank_ctrl #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 2,
  parameter int OPEN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [WIDTH-1:0]  data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WIDTH-1:0]  data1,
  output logic              ack1,
  output logic              err,
  output logic [WIDTH-1:0]  lat_d,
  output logic [DEPTH-1:0]  lat_en,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [3:0] OPEN_LOAD = 4'(OPEN_CYCLES - 1);

  // Decoded enable for an entry; out-of-range addresses decode to all zero,
  // which is what keeps invalid writes from touching any latch.
  function automatic logic [DEPTH-1:0] enable_decode(input logic [ADDR_W-1:0] a);
    logic [DEPTH-1:0] en;
    en = '0;
    for (int i = 0; i < DEPTH; i++) begin
      en[i] = (int'(a) == i);
    end
    return en;
  endfunction

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return (int'(a) < DEPTH);
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              gnt_q, gnt_d;
  logic              pick;
  logic [WIDTH-1:0]  lat_d_d;
  logic [DEPTH-1:0]  lat_en_d;
  logic              ack0_d, ack1_d, err_d, busy_d;

`ifdef LATCH_BANK_CTRL_RR_EN
  // Pointer holds the last granted requester; reset value 1 so that
  // requester 0 wins the first tie.
  logic ptr_q, ptr_d;

  always_comb begin
    pick = (req0 && req1) ? ~ptr_q : req1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    pick = ~req0;
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    gnt_d    = gnt_q;
    lat_d_d  = lat_d;
    lat_en_d = '0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err_d    = 1'b0;
`ifdef LATCH_BANK_CTRL_RR_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d   = pick;
          addr_d  = pick ? addr1 : addr0;
          lat_d_d = pick ? data1 : data0;
          state_d = SETUP;
`ifdef LATCH_BANK_CTRL_RR_EN
          ptr_d   = pick;
`endif
        end
      end
      SETUP: begin
        state_d  = OPEN;
        cnt_d    = OPEN_LOAD;
        lat_en_d = enable_decode(addr_q);
      end
      OPEN: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          err_d   = ~addr_in_range(addr_q);
        end else begin
          cnt_d    = cnt_q - 4'd1;
          lat_en_d = enable_decode(addr_q);
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Registered (Moore) outputs: every output is the value for the state
  // being entered on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      gnt_q   <= 1'b0;
      lat_d   <= '0;
      lat_en  <= '0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      gnt_q   <= gnt_d;
      lat_d   <= lat_d_d;
      lat_en  <= lat_en_d;
      ack0    <= ack0_d;
      ack1    <= ack1_d;
      err     <= err_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Directed testbench for latch_bank_ctrl. Instance dut_a: DEPTH=4,
// OPEN_CYCLES=1. Instance dut_b: DEPTH=3, OPEN_CYCLES=3.
module tb_latch_bank_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a signals
  logic       a_rst, a_req0, a_req1, a_ack0, a_ack1, a_err, a_busy;
  logic [1:0] a_addr0, a_addr1;
  logic [7:0] a_data0, a_data1, a_lat_d;
  logic [3:0] a_lat_en;

  // dut_b signals
  logic       b_rst, b_req0, b_req1, b_ack0, b_ack1, b_err, b_busy;
  logic [1:0] b_addr0, b_addr1;
  logic [7:0] b_data0, b_data1, b_lat_d;
  logic [2:0] b_lat_en;

  int n_pass  = 0;
  int n_total = 0;

  latch_bank_ctrl #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .OPEN_CYCLES(1)) dut_a (
    .clk(clk), .rst(a_rst),
    .req0(a_req0), .addr0(a_addr0), .data0(a_data0), .ack0(a_ack0),
    .req1(a_req1), .addr1(a_addr1), .data1(a_data1), .ack1(a_ack1),
    .err(a_err), .lat_d(a_lat_d), .lat_en(a_lat_en), .busy(a_busy)
  );

  latch_bank_ctrl #(.WIDTH(8), .DEPTH(3), .ADDR_W(2), .OPEN_CYCLES(3)) dut_b (
    .clk(clk), .rst(b_rst),
    .req0(b_req0), .addr0(b_addr0), .data0(b_data0), .ack0(b_ack0),
    .req1(b_req1), .addr1(b_addr1), .data1(b_data1), .ack1(b_ack1),
    .err(b_err), .lat_d(b_lat_d), .lat_en(b_lat_en), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_g [4];
    int lat;
    logic seen;
`ifdef LATCH_BANK_CTRL_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    a_rst = 1'b1; a_req0 = 0; a_req1 = 0; a_addr0 = 0; a_addr1 = 0; a_data0 = 0; a_data1 = 0;
    b_rst = 1'b1; b_req0 = 0; b_req1 = 0; b_addr0 = 0; b_addr1 = 0; b_data0 = 0; b_data1 = 0;
    step(); step();

    chk("rst_a_lat_en", a_lat_en, 0);
    chk("rst_a_lat_d",  a_lat_d,  0);
    chk("rst_a_busy",   a_busy,   0);
    chk("rst_a_acks",   {a_ack0, a_ack1, a_err}, 0);
    chk("rst_b_lat_en", b_lat_en, 0);
    chk("rst_b_busy",   b_busy,   0);
    a_rst = 1'b0; b_rst = 1'b0;
    step();

    // Single write, OPEN_CYCLES=1
    a_req0 = 1; a_addr0 = 2'd2; a_data0 = 8'hA5;
    step();
    chk("w1_setup_lat_d",  a_lat_d,  8'hA5);
    chk("w1_setup_lat_en", a_lat_en, 4'b0000);
    chk("w1_setup_busy",   a_busy,   1);
    chk("w1_setup_ack0",   a_ack0,   0);
    step();
    chk("w1_open_lat_en",  a_lat_en, 4'b0100);
    chk("w1_open_lat_d",   a_lat_d,  8'hA5);
    chk("w1_open_ack0",    a_ack0,   0);
    step();
    chk("w1_hold_ack0",    a_ack0,   1);
    chk("w1_hold_lat_en",  a_lat_en, 4'b0000);
    chk("w1_hold_err",     a_err,    0);
    chk("w1_hold_ack1",    a_ack1,   0);
    chk("w1_hold_lat_d",   a_lat_d,  8'hA5);
    a_req0 = 0;
    step();
    chk("w1_idle_ack0",    a_ack0,   0);
    chk("w1_idle_busy",    a_busy,   0);
    chk("w1_idle_lat_d",   a_lat_d,  8'hA5);

    // Data/address change after grant is ignored
    a_req0 = 1; a_addr0 = 2'd1; a_data0 = 8'h11;
    step();
    chk("chg_setup_lat_d", a_lat_d, 8'h11);
    step();
    chk("chg_open_lat_en", a_lat_en, 4'b0010);
    a_data0 = 8'hFF; a_addr0 = 2'd3;
    step();
    chk("chg_hold_lat_d",  a_lat_d,  8'h11);
    chk("chg_hold_ack0",   a_ack0,   1);
    chk("chg_hold_lat_en", a_lat_en, 4'b0000);
    a_req0 = 0;
    step();
    chk("chg_idle_lat_d",  a_lat_d,  8'h11);
    chk("chg_idle_lat_en", a_lat_en, 4'b0000);

    // Simultaneous requests held continuously, after a fresh reset
    a_rst = 1'b1;
    step();
    a_rst = 1'b0;
    a_req0 = 1; a_addr0 = 2'd0; a_data0 = 8'h10;
    a_req1 = 1; a_addr1 = 2'd3; a_data1 = 8'h20;
    for (int k = 0; k < 4; k++) begin
      lat = 0;
      for (int n = 0; n < 10; n++) begin
        step();
        lat++;
        if (a_ack0 || a_ack1) break;
      end
      chk($sformatf("arb%0d_ack_seen", k), (a_ack0 || a_ack1), 1);
      chk($sformatf("arb%0d_latency", k), lat, (k == 0) ? 3 : 4);
      chk($sformatf("arb%0d_grant", k), {a_ack1, a_ack0}, (exp_g[k] == 1) ? 2'b10 : 2'b01);
      chk($sformatf("arb%0d_lat_d", k), a_lat_d, (exp_g[k] == 1) ? 8'h20 : 8'h10);
    end
    a_req0 = 0; a_req1 = 0;
    step(); step();

    // OPEN_CYCLES=3 write via requester 1
    b_req1 = 1; b_addr1 = 2'd0; b_data1 = 8'h3C;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("oc3_c%0d_busy", c), b_busy, 1);
      chk($sformatf("oc3_c%0d_lat_en", c), b_lat_en, (c >= 1 && c <= 3) ? 3'b001 : 3'b000);
      chk($sformatf("oc3_c%0d_ack1", c), b_ack1, (c == 4));
      chk($sformatf("oc3_c%0d_lat_d", c), b_lat_d, 8'h3C);
    end
    b_req1 = 0;
    step();
    chk("oc3_idle_busy", b_busy, 0);
    chk("oc3_idle_ack1", b_ack1, 0);

    // Out-of-range address (DEPTH=3, addr=3)
    b_req0 = 1; b_addr0 = 2'd3; b_data0 = 8'h77;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("oor_c%0d_lat_en", c), b_lat_en, 3'b000);
      chk($sformatf("oor_c%0d_err", c), b_err, (c == 4));
      chk($sformatf("oor_c%0d_ack0", c), b_ack0, (c == 4));
    end
    b_req0 = 0;
    step();
    chk("oor_idle_err", b_err, 0);

    // Reset during the second OPEN cycle
    b_req0 = 1; b_addr0 = 2'd1; b_data0 = 8'h5A;
    step(); step(); step();
    chk("rmid_open2_lat_en", b_lat_en, 3'b010);
    #2;
    b_rst = 1'b1;
    #1;
    chk("rmid_async_lat_en", b_lat_en, 3'b000);
    chk("rmid_async_lat_d",  b_lat_d,  8'h00);
    chk("rmid_async_busy",   b_busy,   0);
    chk("rmid_async_acks",   {b_ack0, b_ack1}, 2'b00);
    b_req0 = 0;
    step();
    b_rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (b_ack0 || b_ack1) seen = 1'b1;
    end
    chk("rmid_no_ack", seen, 0);
    b_req0 = 1;
    lat = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      lat++;
      if (b_ack0) break;
    end
    chk("rmid_retry_ack0",    b_ack0,  1);
    chk("rmid_retry_latency", lat,     5);
    chk("rmid_retry_lat_d",   b_lat_d, 8'h5A);
    chk("rmid_retry_err",     b_err,   0);
    b_req0 = 0;
    step();
    chk("rmid_retry_idle", b_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
